// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
//   - FSM state encoding
//   - Reconfiguration-IP management register addresses
//   - Counter-word packing helper
//   - Profile ROM holding the (M, C0, C1) counter words for each profile
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MODE,
    WR_M,
    WR_C0,
    WR_C1,
    WR_START,
    WAIT_LOCK,
    ERROR
  } state_t;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;

  // Mode register value 0 selects waitrequest mode. In this mode the start
  // write stalls until reconfiguration has finished.
  localparam logic [31:0] MODE_WAITREQ = 32'd0;
  localparam logic [31:0] START_GO     = 32'd1;

  // Counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd duty,
  // [22:18] counter select (only meaningful for C counters).
  function automatic logic [31:0] pack_counter(input logic [7:0] hi,
                                               input logic [7:0] lo,
                                               input logic       bypass,
                                               input logic       odd,
                                               input logic [4:0] sel);
    pack_counter = {9'd0, sel, odd, bypass, hi, lo};
  endfunction

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] c0;
    logic [31:0] c1;
  } profile_t;

  localparam int PROFILE_ROM_DEPTH = 2;

  // Both profiles use a 122.88 MHz reference and VCO = 491.52 MHz (M = 4).
  //   profile 0: C0 = 2 -> 245.76 MHz, C1 = 4 -> 122.88 MHz
  //   profile 1: C0 = 4 -> 122.88 MHz, C1 = 8 ->  61.44 MHz
  localparam profile_t PROFILE_ROM [PROFILE_ROM_DEPTH] = '{
    '{m:  pack_counter(8'd2, 8'd2, 1'b0, 1'b0, 5'd0),
      c0: pack_counter(8'd1, 8'd1, 1'b0, 1'b0, 5'd0),
      c1: pack_counter(8'd2, 8'd2, 1'b0, 1'b0, 5'd1)},
    '{m:  pack_counter(8'd2, 8'd2, 1'b0, 1'b0, 5'd0),
      c0: pack_counter(8'd2, 8'd2, 1'b0, 1'b0, 5'd0),
      c1: pack_counter(8'd4, 8'd4, 1'b0, 1'b0, 5'd1)}
  };

  // Out-of-range indices return zeros. The sequencer never issues writes for
  // such indices, so that value is never driven onto the bus.
  function automatic profile_t profile_lookup(input int unsigned idx);
    profile_t p;
    p = '0;
    case (idx)
      0:       p = PROFILE_ROM[0];
      1:       p = PROFILE_ROM[1];
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_lock_qualifier.sv
// Debounces the (already synchronized) PLL lock flag.
// A saturating counter runs while locked is high and clears on any low cycle.
// The output stable is high once LOCK_CYCLES consecutive high cycles have
// been seen.
//   clk, rst     : management clock, synchronous active-high reset
//   clr          : holds the counter at zero (asserted during the start write)
//   locked       : PLL lock input
//   stable       : counter == LOCK_CYCLES
//   stable_next  : stable will be high on the next cycle
module lock_qualifier #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic locked,
  output logic stable,
  output logic stable_next
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clr || !locked) begin
      cnt_next = '0;
    end else if (cnt != LOCK_MAX) begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign stable      = (cnt == LOCK_MAX);
  assign stable_next = (cnt_next == LOCK_MAX);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Run-time PLL retune sequencer. When the host requests it, the sequencer
// writes the stored M/C0/C1 profile to the reconfiguration IP and triggers
// reconfiguration. It then waits for a debounced lock before it reports done.
//   clk, rst            : management clock, synchronous active-high reset
//   cfg_start           : one-cycle request, ignored while busy
//   cfg_profile         : profile index, latched together with cfg_start
//   pll_locked          : PLL lock, already in the clk domain
//   mgmt_address/write/writedata/waitrequest : Avalon-MM master to the IP
//   busy                : request in progress
//   done                : one-cycle success pulse (same cycle busy falls)
//   err                 : sticky error, cleared by the next accepted request
//   active_profile      : last profile that completed successfully
//   pll_stable          : debounced lock status
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES   = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 1 << 20,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [PW-1:0] cfg_profile,
  input  logic          pll_locked,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  input  logic          mgmt_waitrequest,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] active_profile,
  output logic          pll_stable
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [PW-1:0] prof_idx;
  logic [TW-1:0] tmo_cnt;
  profile_t      prof;

  logic          idx_ok;
  logic          accept;
  logic          done_set;
  logic          err_set;
  logic          qual_clr;
  logic          stable_next;
  logic          wr;
  logic [5:0]    addr;
  logic [31:0]   wdata;

  lock_qualifier #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_qualifier (
    .clk         (clk),
    .rst         (rst),
    .clr         (qual_clr),
    .locked      (pll_locked),
    .stable      (pll_stable),
    .stable_next (stable_next)
  );

  // Indices past the ROM are also rejected so that an oversized NUM_PROFILES
  // cannot reach an empty profile.
  assign idx_ok = (32'(cfg_profile) < 32'(NUM_PROFILES)) &&
                  (32'(cfg_profile) < 32'(PROFILE_ROM_DEPTH));

  assign prof = profile_lookup(32'(prof_idx));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    qual_clr   = 1'b0;
    wr         = 1'b0;
    addr       = '0;
    wdata      = '0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          accept     = 1'b1;
          state_next = idx_ok ? WR_MODE : ERROR;
        end
      end
      WR_MODE: begin
        wr    = 1'b1;
        addr  = ADDR_MODE;
        wdata = MODE_WAITREQ;
        if (!mgmt_waitrequest) state_next = WR_M;
      end
      WR_M: begin
        wr    = 1'b1;
        addr  = ADDR_M;
        wdata = prof.m;
        if (!mgmt_waitrequest) state_next = WR_C0;
      end
      WR_C0: begin
        wr    = 1'b1;
        addr  = ADDR_C;
        wdata = prof.c0;
        if (!mgmt_waitrequest) state_next = WR_C1;
      end
      WR_C1: begin
        wr    = 1'b1;
        addr  = ADDR_C;
        wdata = prof.c1;
        if (!mgmt_waitrequest) state_next = WR_START;
      end
      WR_START: begin
        // The start write stalls for the whole reconfiguration. Lock seen
        // before its acceptance does not count towards stability.
        wr       = 1'b1;
        addr     = ADDR_START;
        wdata    = START_GO;
        qual_clr = 1'b1;
        if (!mgmt_waitrequest) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Success is checked first so it wins a tie with the timeout.
        if (stable_next) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      ERROR: begin
        err_set    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prof_idx       <= '0;
      tmo_cnt        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      active_profile <= '0;
    end else begin
      state <= state_next;
      done  <= done_set;
      if (accept) prof_idx <= cfg_profile;
      if (err_set) begin
        err <= 1'b1;
      end else if (accept) begin
        err <= 1'b0;
      end
      if (done_set) active_profile <= prof_idx;
      // Zero on entry to WAIT_LOCK because it is held clear everywhere else.
      tmo_cnt <= (state == WAIT_LOCK) ? tmo_cnt + TW'(1) : '0;
    end
  end

  assign busy           = (state != IDLE);
  assign mgmt_write     = wr;
  assign mgmt_address   = addr;
  assign mgmt_writedata = wdata;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq. The DUT uses LOCK_CYCLES = 1024 and
// TIMEOUT_CYCLES = 4096. NUM_PROFILES is 3 so that cfg_profile is 2 bits wide
// and index 3 can be driven. Index 3 is out of range and must be rejected.
module tb_pll_reconfig_seq;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [1:0]  cfg_profile;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  active_profile;
  logic        pll_stable;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  pll_reconfig_seq #(
    .NUM_PROFILES   (3),
    .LOCK_CYCLES    (1024),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_profile      (cfg_profile),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .active_profile   (active_profile),
    .pll_stable       (pll_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted Avalon writes
  always @(posedge clk) begin
    if (!rst && mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0)
      wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] idx);
    cfg_profile = idx;
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  // Entered while the DUT presents a write. The write is stalled for 'stall'
  // cycles and then accepted. Returns one cycle after acceptance.
  task automatic do_write(input string tag, input logic [5:0] a,
                          input logic [31:0] d, input int stall);
    int ok;
    chk({tag, "_wr"},   32'(mgmt_write),   32'd1);
    chk({tag, "_addr"}, 32'(mgmt_address), 32'(a));
    chk({tag, "_data"}, mgmt_writedata,    d);
    if (stall > 0) begin
      ok = 1;
      mgmt_waitrequest = 1'b1;
      for (int k = 0; k < stall; k++) begin
        tick();
        if (mgmt_write !== 1'b1 || mgmt_address !== a || mgmt_writedata !== d) ok = 0;
      end
      chk({tag, "_hold"}, 32'(ok), 32'd1);
      mgmt_waitrequest = 1'b0;
    end
    tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;
    rst              = 1'b1;
    cfg_start        = 1'b0;
    cfg_profile      = 2'd0;
    pll_locked       = 1'b0;
    mgmt_waitrequest = 1'b0;
    tick(); tick(); tick();

    chk("rst_busy",   32'(busy),           32'd0);
    chk("rst_done",   32'(done),           32'd0);
    chk("rst_err",    32'(err),            32'd0);
    chk("rst_active", 32'(active_profile), 32'd0);
    chk("rst_stable", 32'(pll_stable),     32'd0);
    chk("rst_write",  32'(mgmt_write),     32'd0);
    chk("rst_addr",   32'(mgmt_address),   32'd0);
    chk("rst_data",   mgmt_writedata,      32'd0);
    rst = 1'b0;
    tick();

    // Profile 0, no stalls, lock held high
    pll_locked = 1'b1;
    request(2'd0);
    chk("p0_busy", 32'(busy), 32'd1);
    do_write("p0_mode", 6'h00, 32'h0,     0);
    do_write("p0_m",    6'h04, 32'h0202,  0);
    do_write("p0_c0",   6'h05, 32'h0101,  0);
    do_write("p0_c1",   6'h05, 32'h40202, 0);
    do_write("p0_go",   6'h02, 32'h1,     0);
    chk("p0_entry_stable", 32'(pll_stable), 32'd0);
    chk("p0_entry_write",  32'(mgmt_write), 32'd0);
    chk("p0_entry_busy",   32'(busy),       32'd1);
    wait_done(n);
    chk("p0_latency", 32'(n),              32'd1024);
    chk("p0_busy_lo", 32'(busy),           32'd0);
    chk("p0_active",  32'(active_profile), 32'd0);
    chk("p0_stable",  32'(pll_stable),     32'd1);
    chk("p0_err",     32'(err),            32'd0);
    chk("p0_wrcount", 32'(wr_count),       32'd5);
    tick();
    chk("p0_done_pulse", 32'(done), 32'd0);

    // Profile 1 with 3-cycle stalls and a 500-cycle start stall
    request(2'd1);
    do_write("p1_mode", 6'h00, 32'h0,     3);
    do_write("p1_m",    6'h04, 32'h0202,  3);
    do_write("p1_c0",   6'h05, 32'h0202,  3);
    do_write("p1_c1",   6'h05, 32'h40404, 3);
    do_write("p1_go",   6'h02, 32'h1,     500);
    chk("p1_entry_stable", 32'(pll_stable), 32'd0);
    wait_done(n);
    chk("p1_latency", 32'(n),              32'd1024);
    chk("p1_active",  32'(active_profile), 32'd1);
    chk("p1_wrcount", 32'(wr_count),       32'd10);
    tick();

    // Lock drops for one cycle 800 cycles into WAIT_LOCK, and again 800
    // cycles later. After that a full 1024-cycle run is needed.
    request(2'd1);
    do_write("tg_mode", 6'h00, 32'h0,     0);
    do_write("tg_m",    6'h04, 32'h0202,  0);
    do_write("tg_c0",   6'h05, 32'h0202,  0);
    do_write("tg_c1",   6'h05, 32'h40404, 0);
    do_write("tg_go",   6'h02, 32'h1,     0);
    bad = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 799; k++) begin
        tick();
        if (done !== 1'b0 || pll_stable !== 1'b0) bad = 1;
      end
      pll_locked = 1'b0;
      tick();
      if (done !== 1'b0 || pll_stable !== 1'b0) bad = 1;
      pll_locked = 1'b1;
    end
    chk("tg_no_early", 32'(bad), 32'd0);
    chk("tg_busy",     32'(busy), 32'd1);
    wait_done(n);
    chk("tg_latency", 32'(n),              32'd1024);
    chk("tg_stable",  32'(pll_stable),     32'd1);
    chk("tg_active",  32'(active_profile), 32'd1);
    tick();

    // Lock stuck low, so the request times out after 4096 cycles in WAIT_LOCK
    pll_locked = 1'b0;
    request(2'd0);
    do_write("to_mode", 6'h00, 32'h0,     0);
    do_write("to_m",    6'h04, 32'h0202,  0);
    do_write("to_c0",   6'h05, 32'h0101,  0);
    do_write("to_c1",   6'h05, 32'h40202, 0);
    do_write("to_go",   6'h02, 32'h1,     0);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n),              32'd4096);
    chk("to_err",    32'(err),            32'd1);
    chk("to_done",   32'(done),           32'd0);
    chk("to_active", 32'(active_profile), 32'd1);
    chk("to_stable", 32'(pll_stable),     32'd0);
    tick();

    // Out-of-range index: error, no writes, and err cleared by the next request
    request(2'd3);
    chk("bad_busy",     32'(busy),       32'd1);
    chk("bad_write",    32'(mgmt_write), 32'd0);
    chk("bad_err_clr",  32'(err),        32'd0);
    tick();
    chk("bad_err",      32'(err),        32'd1);
    chk("bad_busy_lo",  32'(busy),       32'd0);
    tick();
    chk("bad_wrcount",  32'(wr_count),   32'd20);
    pll_locked = 1'b1;
    request(2'd0);
    chk("clr_err",  32'(err),  32'd0);
    chk("clr_busy", 32'(busy), 32'd1);

    // A second request while busy, then reset during the C0 stall
    cfg_profile = 2'd1;
    cfg_start   = 1'b1;
    do_write("rs_mode", 6'h00, 32'h0, 0);
    cfg_start   = 1'b0;
    do_write("rs_m",    6'h04, 32'h0202, 0);
    chk("rs_c0_addr", 32'(mgmt_address), 32'h05);
    mgmt_waitrequest = 1'b1;
    tick(); tick();
    chk("rs_c0_hold", mgmt_writedata, 32'h0101);
    rst = 1'b1;
    tick();
    chk("rs_busy",   32'(busy),           32'd0);
    chk("rs_write",  32'(mgmt_write),     32'd0);
    chk("rs_addr",   32'(mgmt_address),   32'd0);
    chk("rs_data",   mgmt_writedata,      32'd0);
    chk("rs_done",   32'(done),           32'd0);
    chk("rs_err",    32'(err),            32'd0);
    chk("rs_active", 32'(active_profile), 32'd0);
    chk("rs_stable", 32'(pll_stable),     32'd0);
    rst = 1'b0;
    mgmt_waitrequest = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mgmt_write !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("rs_quiet",   32'(bad),      32'd0);
    chk("rs_wrcount", 32'(wr_count), 32'd22);

    // Idle lock loss: pll_stable falls one cycle later and err stays clear
    n = 0;
    while (pll_stable !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_stable_hi", 32'(pll_stable), 32'd1);
    pll_locked = 1'b0;
    tick();
    chk("idle_stable_lo", 32'(pll_stable), 32'd0);
    chk("idle_err",       32'(err),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
